lcd_seq_arbiter: RTL

Sequencer and two-port arbiter for the 4-bit HD44780-style character LCD driven from `Top` (`LCD_Data`, `LCD_E`, `LCD_RS`, `LCD_RW`). It runs the power-on initialisation and then grants the LCD bus round-robin to two byte requesters, for example the pipeline status display and the BTB statistics display. For each accepted byte it generates the nibble split, the E strobe timing and the post-command execution wait.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_delay_timer.sv | 38 +++
 rtl/lcd_seq_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and default timing for the LCD sequencer/arbiter.
package lcd_pkg;

    localparam int unsigned TIM_W = 20;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_NIB  = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_IDLE      = 3'd3,
        ST_SETUP     = 3'd4,
        ST_E_HI      = 3'd5,
        ST_HOLD      = 3'd6,
        ST_EXEC      = 3'd7
    } lcd_state_t;

    localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;

    localparam int unsigned DEF_T_PWRUP   = 750000;
    localparam int unsigned DEF_T_INIT1   = 205000;
    localparam int unsigned DEF_T_INIT2   = 5000;
    localparam int unsigned DEF_T_SETUP   = 2;
    localparam int unsigned DEF_T_E_HIGH  = 12;
    localparam int unsigned DEF_T_NIB_GAP = 50;
    localparam int unsigned DEF_T_CMD     = 2000;
    localparam int unsigned DEF_T_CLR     = 82000;

    // Clear display and return-home commands need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter: after Load with N, Done is high on the Nth cycle of the phase.
module lcd_delay_timer
    import lcd_pkg::*;
#(
    parameter logic [TIM_W-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [TIM_W-1:0] Value,
    output logic             Done
);

    logic [TIM_W-1:0] count_d, count_q;

    // Load N-1 so that a phase of length N ends when the count reaches zero.
    always_comb begin
        if (Load) begin
            count_d = Value - 20'd1;
        end else if (count_q != 20'd0) begin
            count_d = count_q - 20'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign Done = (count_q == 20'd0);

endmodule

// File: rtl/lcd_seq_arbiter.sv
// HD44780 4-bit LCD sequencer with round-robin arbitration between two byte requesters.
// Define LCD_SEQ_INIT_EN to run the power-on init sequence after every reset.
module lcd_seq_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP   = DEF_T_PWRUP,
    parameter int unsigned T_INIT1   = DEF_T_INIT1,
    parameter int unsigned T_INIT2   = DEF_T_INIT2,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_E_HIGH  = DEF_T_E_HIGH,
    parameter int unsigned T_NIB_GAP = DEF_T_NIB_GAP,
    parameter int unsigned T_CMD     = DEF_T_CMD,
    parameter int unsigned T_CLR     = DEF_T_CLR
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       ReqA,
    input  logic       ReqB,
    input  logic       RsA,
    input  logic       RsB,
    input  logic [7:0] DataA,
    input  logic [7:0] DataB,
    output logic       GntA,
    output logic       GntB,
    output logic       Ready,
    output logic [3:0] LCD_Data,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

`ifdef LCD_SEQ_INIT_EN
    localparam lcd_state_t RST_STATE  = ST_PWRUP;
    localparam logic [3:0] INIT_STEPS = 4'd8;
`else
    localparam lcd_state_t RST_STATE  = ST_IDLE;
`endif

    lcd_state_t       state_d, state_q;
    logic [7:0]       byte_d, byte_q;
    logic             rs_d, rs_q;
    logic             nib_d, nib_q;
    logic             last_b_d, last_b_q;
    logic             ready_d, ready_q;
    logic [3:0]       lcd_data_d, lcd_data_q;
    logic             lcd_e_d, lcd_e_q;
    logic             lcd_rs_d, lcd_rs_q;
    logic             gnt_a_s, gnt_b_s;
    logic             single_nib_s;
    logic             tmr_load_s, tmr_done_s;
    logic [TIM_W-1:0] tmr_value_s;

`ifdef LCD_SEQ_INIT_EN
    logic [3:0] step_d, step_q;

    // Steps 0-3 are lone init nibbles (kept in the high half), steps 4-7 full bytes.
    function automatic logic [7:0] init_byte(input logic [3:0] step);
        case (step)
            4'd0, 4'd1, 4'd2: init_byte = 8'h30;
            4'd3:             init_byte = 8'h20;
            4'd4:             init_byte = LCD_FUNC_4BIT;
            4'd5:             init_byte = LCD_ENTRY_INC;
            4'd6:             init_byte = LCD_DISP_ON;
            4'd7:             init_byte = LCD_CLEAR;
            default:          init_byte = 8'h00;
        endcase
    endfunction

    assign single_nib_s = (step_q < 4'd4);
`else
    assign single_nib_s = 1'b0;
`endif

    lcd_delay_timer #(
        .RST_VAL (TIM_W'(T_PWRUP - 1))
    ) u_timer (
        .Clk   (Clk),
        .Rst   (Rst),
        .Load  (tmr_load_s),
        .Value (tmr_value_s),
        .Done  (tmr_done_s)
    );

    // Round-robin arbitration; ready_q masks the first IDLE cycle straight out of reset.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if ((state_q == ST_IDLE) && ready_q) begin
            if (ReqA && (!ReqB || last_b_q)) begin
                gnt_a_s = 1'b1;
            end else begin
                gnt_b_s = ReqB;
            end
        end else begin
            gnt_a_s = 1'b0;
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        nib_d    = nib_q;
        last_b_d = last_b_q;
`ifdef LCD_SEQ_INIT_EN
        step_d   = step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_a_s || gnt_b_s) begin
                    byte_d   = gnt_b_s ? DataB : DataA;
                    rs_d     = gnt_b_s ? RsB : RsA;
                    nib_d    = 1'b0;
                    last_b_d = gnt_b_s;
                    state_d  = ST_SETUP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_done_s) state_d = ST_E_HI;
                else            state_d = ST_SETUP;
            end
            ST_E_HI: begin
                if (tmr_done_s) state_d = ST_HOLD;
                else            state_d = ST_E_HI;
            end
            ST_HOLD: begin
                if (!tmr_done_s) begin
                    state_d = ST_HOLD;
                end else if (single_nib_s) begin
                    state_d = ST_INIT_WAIT;
                end else if (!nib_q) begin
                    nib_d   = 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!tmr_done_s) begin
                    state_d = ST_EXEC;
`ifdef LCD_SEQ_INIT_EN
                end else if (step_q != INIT_STEPS) begin
                    step_d  = step_q + 4'd1;
                    state_d = (step_q == INIT_STEPS - 4'd1) ? ST_IDLE : ST_INIT_NIB;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef LCD_SEQ_INIT_EN
            ST_PWRUP: begin
                if (tmr_done_s) state_d = ST_INIT_NIB;
                else            state_d = ST_PWRUP;
            end
            ST_INIT_NIB: begin
                byte_d  = init_byte(step_q);
                rs_d    = 1'b0;
                nib_d   = 1'b0;
                state_d = ST_SETUP;
            end
            ST_INIT_WAIT: begin
                if (tmr_done_s) begin
                    step_d  = step_q + 4'd1;
                    state_d = ST_INIT_NIB;
                end else begin
                    state_d = ST_INIT_WAIT;
                end
            end
`endif
            default: state_d = RST_STATE;
        endcase
    end

    // Every state change starts a new timed phase sized for the state being entered.
    always_comb begin
        tmr_load_s = (state_d != state_q);
        case (state_d)
            ST_SETUP: tmr_value_s = TIM_W'(T_SETUP);
            ST_E_HI:  tmr_value_s = TIM_W'(T_E_HIGH);
            ST_HOLD:  tmr_value_s = TIM_W'(T_NIB_GAP);
            ST_EXEC:  tmr_value_s = is_long_cmd(rs_d, byte_d) ? TIM_W'(T_CLR) : TIM_W'(T_CMD);
`ifdef LCD_SEQ_INIT_EN
            ST_INIT_WAIT: begin
                case (step_q)
                    4'd0:    tmr_value_s = TIM_W'(T_INIT1);
                    4'd1:    tmr_value_s = TIM_W'(T_INIT2);
                    default: tmr_value_s = TIM_W'(T_CMD);
                endcase
            end
`endif
            default:  tmr_value_s = 20'd1;
        endcase
    end

    // Output flops follow the next state so they line up with the state register.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        lcd_e_d = (state_d == ST_E_HI);
        if (state_d inside {ST_SETUP, ST_E_HI, ST_HOLD}) begin
            lcd_data_d = nib_d ? byte_d[3:0] : byte_d[7:4];
            lcd_rs_d   = rs_d;
        end else begin
            lcd_data_d = 4'h0;
            lcd_rs_d   = 1'b0;
        end
    end

    // State and output registers; the pointer resets as if B was served last.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= RST_STATE;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            nib_q      <= 1'b0;
            last_b_q   <= 1'b1;
            ready_q    <= 1'b0;
            lcd_data_q <= 4'h0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
`ifdef LCD_SEQ_INIT_EN
            step_q     <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            nib_q      <= nib_d;
            last_b_q   <= last_b_d;
            ready_q    <= ready_d;
            lcd_data_q <= lcd_data_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
`ifdef LCD_SEQ_INIT_EN
            step_q     <= step_d;
`endif
        end
    end

    assign GntA     = gnt_a_s;
    assign GntB     = gnt_b_s;
    assign Ready    = ready_q;
    assign LCD_Data = lcd_data_q;
    assign LCD_E    = lcd_e_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = 1'b0;

endmodule
